// File: rtl/mips32_loader_pkg.sv
// Shared definitions for the mips32 program loader: header field layout,
// region encodings and loader FSM states.
package mips32_loader_pkg;

  localparam int unsigned LAST_BIT   = 31;
  localparam int unsigned REGION_BIT = 30;
  localparam int unsigned LEN_LSB    = 16;
  localparam int unsigned LEN_W      = 10;

  localparam logic REG_CODE = 1'b0;
  localparam logic REG_DATA = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StFlush,
    StRun
  } loader_state_e;

endpackage

// File: rtl/mips32_prog_loader.sv
// Streaming boot loader: parses segment headers from a valid/ready word stream,
// writes payload into code/data memory and holds the core until the last segment lands.
module mips32_prog_loader
  import mips32_loader_pkg::*;
#(
  parameter int unsigned AW = 10,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          load_req,
  output logic          mem_we,
  output logic          mem_sel,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          cpu_run,
  output logic          busy,
  output logic          err,
  output logic [DW-1:0] chk
);

  loader_state_e state_q, state_d;

  logic             region_q, region_d;
  logic             last_q, last_d;
  logic [AW-1:0]    base_q, base_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             mem_we_d, mem_sel_d;
  logic [AW-1:0]    mem_addr_d;
  logic [DW-1:0]    mem_wdata_d;
  logic             err_d;
  logic [DW-1:0]    chk_d;

  logic             xfer;
  logic [LEN_W-1:0] hdr_len;

  assign s_ready = (state_q == StHdr) || (state_q == StData);
  assign busy    = s_ready || (state_q == StFlush);
  assign cpu_run = (state_q == StRun);
  assign xfer    = s_valid && s_ready;
  assign hdr_len = s_data[LEN_LSB +: LEN_W];

  always_comb begin
    state_d     = state_q;
    region_d    = region_q;
    last_d      = last_q;
    base_d      = base_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_sel_d   = mem_sel;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    err_d       = err;
    chk_d       = chk;

    unique case (state_q)
      StIdle: state_d = StHdr;
      StHdr: begin
        if (xfer) begin
          if (hdr_len == '0) begin
            // Empty segment is skipped; the stream continues with the next header.
            err_d = 1'b1;
          end else begin
            region_d = s_data[REGION_BIT];
            last_d   = s_data[LAST_BIT];
            base_d   = s_data[AW-1:0];
            len_d    = hdr_len;
            cnt_d    = '0;
            state_d  = StData;
          end
        end
      end
      StData: begin
        if (xfer) begin
          mem_we_d    = 1'b1;
          mem_sel_d   = region_q;
          mem_addr_d  = base_q + AW'(cnt_q);
          mem_wdata_d = s_data;
          chk_d       = chk ^ s_data;
          cnt_d       = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) begin
            state_d = last_q ? StFlush : StHdr;
          end
        end
      end
      StFlush: state_d = StRun;
      StRun: begin
        if (load_req) begin
          state_d = StHdr;
          chk_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      region_q  <= REG_CODE;
      last_q    <= 1'b0;
      base_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      mem_we    <= 1'b0;
      mem_sel   <= REG_CODE;
      mem_addr  <= '0;
      mem_wdata <= '0;
      err       <= 1'b0;
      chk       <= '0;
    end else begin
      state_q   <= state_d;
      region_q  <= region_d;
      last_q    <= last_d;
      base_q    <= base_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      mem_we    <= mem_we_d;
      mem_sel   <= mem_sel_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      err       <= err_d;
      chk       <= chk_d;
    end
  end

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed self-checking bench for mips32_prog_loader.
module tb_mips32_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        load_req;
  logic        mem_we;
  logic        mem_sel;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_run;
  logic        busy;
  logic        err;
  logic [31:0] chk;

  int total = 0;
  int bad   = 0;

  mips32_prog_loader #(
    .AW(10),
    .DW(32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .load_req (load_req),
    .mem_we   (mem_we),
    .mem_sel  (mem_sel),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .cpu_run  (cpu_run),
    .busy     (busy),
    .err      (err),
    .chk      (chk)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stream input and sample just after the edge.
  task automatic step(input logic v, input logic [31:0] d);
    s_valid = v;
    s_data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input string tag, input logic sel, input logic [9:0] addr,
                           input logic [31:0] data);
    check({tag, ".we"}, 32'(mem_we), 32'd1);
    check({tag, ".sel"}, 32'(mem_sel), 32'(sel));
    check({tag, ".addr"}, 32'(mem_addr), 32'(addr));
    check({tag, ".wdata"}, mem_wdata, data);
  endtask

  task automatic expect_nowr(input string tag);
    check({tag, ".nowe"}, 32'(mem_we), 32'd0);
  endtask

  task automatic reload();
    load_req = 1'b1;
    step(1'b0, 32'h0);
    load_req = 1'b0;
  endtask

  initial begin
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = 32'h0;
    load_req = 1'b0;
    #1;
    check("rst.s_ready", 32'(s_ready), 32'd0);
    check("rst.mem_we", 32'(mem_we), 32'd0);
    check("rst.cpu_run", 32'(cpu_run), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.err", 32'(err), 32'd0);
    check("rst.chk", chk, 32'h0);
    check("rst.addr", 32'(mem_addr), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("idle.s_ready", 32'(s_ready), 32'd0);
    step(1'b0, 32'h0);
    check("hdr.s_ready", 32'(s_ready), 32'd1);
    check("hdr.busy", 32'(busy), 32'd1);

    // Code load, valid held high
    step(1'b1, 32'h0002_0000);
    expect_nowr("load.h0");
    step(1'b1, 32'h03E0_A800);
    expect_wr("load.w0", 1'b0, 10'd0, 32'h03E0_A800);
    step(1'b1, 32'h07E0_A800);
    expect_wr("load.w1", 1'b0, 10'd1, 32'h07E0_A800);
    step(1'b1, 32'hC001_0026);
    expect_nowr("load.h1");
    step(1'b1, 32'h0000_0004);
    expect_wr("load.w2", 1'b1, 10'd38, 32'h0000_0004);
    check("load.flush.cpu_run", 32'(cpu_run), 32'd0);
    check("load.flush.s_ready", 32'(s_ready), 32'd0);
    check("load.flush.busy", 32'(busy), 32'd1);
    step(1'b1, 32'hDEAD_BEEF);
    check("load.run.cpu_run", 32'(cpu_run), 32'd1);
    check("load.run.busy", 32'(busy), 32'd0);
    check("load.run.s_ready", 32'(s_ready), 32'd0);
    expect_nowr("load.run");
    check("load.chk", chk, 32'h0400_0004);
    step(1'b1, 32'hDEAD_BEEF);
    check("run.ignore.cpu_run", 32'(cpu_run), 32'd1);

    // Reload, then same stream with valid low on alternate cycles
    reload();
    check("reload.cpu_run", 32'(cpu_run), 32'd0);
    check("reload.chk", chk, 32'h0);
    check("reload.err", 32'(err), 32'd0);
    check("reload.s_ready", 32'(s_ready), 32'd1);
    step(1'b1, 32'h0002_0000);
    expect_nowr("stall.h0");
    step(1'b0, 32'hFFFF_FFFF);
    expect_nowr("stall.g0");
    step(1'b1, 32'h03E0_A800);
    expect_wr("stall.w0", 1'b0, 10'd0, 32'h03E0_A800);
    step(1'b0, 32'hFFFF_FFFF);
    expect_nowr("stall.g1");
    step(1'b1, 32'h07E0_A800);
    expect_wr("stall.w1", 1'b0, 10'd1, 32'h07E0_A800);
    step(1'b0, 32'hFFFF_FFFF);
    expect_nowr("stall.g2");
    step(1'b1, 32'hC001_0026);
    expect_nowr("stall.h1");
    step(1'b0, 32'hFFFF_FFFF);
    expect_nowr("stall.g3");
    check("stall.g3.cpu_run", 32'(cpu_run), 32'd0);
    step(1'b1, 32'h0000_0004);
    expect_wr("stall.w2", 1'b1, 10'd38, 32'h0000_0004);
    check("stall.flush.cpu_run", 32'(cpu_run), 32'd0);
    step(1'b0, 32'h0);
    check("stall.run.cpu_run", 32'(cpu_run), 32'd1);
    check("stall.chk", chk, 32'h0400_0004);

    // Address wrap, then zero-length LAST header, then a real LAST segment
    reload();
    step(1'b1, 32'h0002_03FF);
    expect_nowr("wrap.h");
    step(1'b1, 32'h1111_0000);
    expect_wr("wrap.w0", 1'b0, 10'd1023, 32'h1111_0000);
    step(1'b1, 32'h0000_2222);
    expect_wr("wrap.w1", 1'b0, 10'd0, 32'h0000_2222);
    check("wrap.err", 32'(err), 32'd0);
    check("wrap.s_ready", 32'(s_ready), 32'd1);
    step(1'b1, 32'h8000_0010);
    expect_nowr("zero.h");
    check("zero.err", 32'(err), 32'd1);
    check("zero.s_ready", 32'(s_ready), 32'd1);
    check("zero.cpu_run", 32'(cpu_run), 32'd0);
    step(1'b1, 32'hC001_0005);
    expect_nowr("zero.h2");
    step(1'b1, 32'h1234_5678);
    expect_wr("zero.w", 1'b1, 10'd5, 32'h1234_5678);
    step(1'b0, 32'h0);
    check("zero.run.cpu_run", 32'(cpu_run), 32'd1);
    check("zero.run.err", 32'(err), 32'd1);
    check("zero.chk", chk, 32'h0325_745A);

    // Async reset in the middle of a data segment
    reload();
    step(1'b1, 32'h0003_0010);
    step(1'b1, 32'hAAAA_0001);
    expect_wr("arst.w0", 1'b0, 10'd16, 32'hAAAA_0001);
    s_data = 32'hAAAA_0002;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.mem_we", 32'(mem_we), 32'd0);
    check("arst.s_ready", 32'(s_ready), 32'd0);
    check("arst.busy", 32'(busy), 32'd0);
    check("arst.chk", chk, 32'h0);
    check("arst.addr", 32'(mem_addr), 32'd0);
    check("arst.wdata", mem_wdata, 32'h0);
    @(posedge clk);
    #1;
    check("arst.hold.mem_we", 32'(mem_we), 32'd0);
    rst_n = 1'b1;
    check("arst.rel.s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("arst.hdr.s_ready", 32'(s_ready), 32'd1);
    expect_nowr("arst.hdr");
    check("arst.hdr.cpu_run", 32'(cpu_run), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
